// File: rtl/axi_lite_pkg.sv
// Shared encodings for the AXI4-Lite command master: FSM states, response codes
// and the data pattern returned when a phase times out.
package axi_lite_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WR      = 4'd1;
  localparam logic [3:0] ST_WR_RESP = 4'd2;
  localparam logic [3:0] ST_RD_ADDR = 4'd3;
  localparam logic [3:0] ST_RD_DATA = 4'd4;
  localparam logic [3:0] ST_RSP     = 4'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  // States in which the master is waiting on the slave.
  function automatic logic is_wait_state(input logic [3:0] st);
    return (st == ST_WR) || (st == ST_WR_RESP) || (st == ST_RD_ADDR) || (st == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axi_lite_master_cmd_if.sv
// Single-outstanding command port to AXI4-Lite master bridge.
// Optional per-phase watchdog is compiled in with `define AXI_LITE_MST_TIMEOUT_EN.
module axi_lite_master_cmd_if
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,

  output logic        m_axi_awvalid,
  output logic [31:0] m_axi_awaddr,
  input  logic        m_axi_awready,
  output logic        m_axi_wvalid,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_bready,
  output logic        m_axi_arvalid,
  output logic [31:0] m_axi_araddr,
  input  logic        m_axi_arready,
  input  logic        m_axi_rvalid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  output logic        m_axi_rready
);

  logic [3:0]  state_reg, state_next;
  logic        cmd_ready_reg, cmd_ready_next;
  logic        write_reg, write_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg, w_done_next;
  logic        bready_reg, bready_next;
  logic        arvalid_reg, arvalid_next;
  logic        rready_reg, rready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]  rsp_resp_reg, rsp_resp_next;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, cmd_fire;
  logic aw_done_now, w_done_now;
  logic timeout_hit;

  assign cmd_fire    = cmd_valid & cmd_ready_reg;
  assign aw_fire     = awvalid_reg & m_axi_awready;
  assign w_fire      = wvalid_reg & m_axi_wready;
  assign b_fire      = bready_reg & m_axi_bvalid;
  assign ar_fire     = arvalid_reg & m_axi_arready;
  assign r_fire      = rready_reg & m_axi_rvalid;
  assign aw_done_now = aw_done_reg | aw_fire;
  assign w_done_now  = w_done_reg | w_fire;

`ifdef AXI_LITE_MST_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;

  // Restarts whenever the state changes, so each AXI phase gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      tmo_cnt_reg <= '0;
    end else if (is_wait_state(state_reg)) begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  assign timeout_hit = is_wait_state(state_reg) && (tmo_cnt_reg == TIMEOUT_CYCLES - 16'd1);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b1;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= cmd_ready_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

  // IDLE with cmd_ready low means a command is latched and the channel is launched next.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (!cmd_ready_reg) state_next = write_reg ? ST_WR : ST_RD_ADDR;
      ST_WR:      if (aw_done_now && w_done_now) state_next = ST_WR_RESP;
      ST_WR_RESP: if (b_fire) state_next = ST_RSP;
      ST_RD_ADDR: if (ar_fire) state_next = ST_RD_DATA;
      ST_RD_DATA: if (r_fire) state_next = ST_RSP;
      ST_RSP:     if (rsp_valid_reg && rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (timeout_hit) state_next = ST_RSP;
  end

  always_comb begin
    cmd_ready_next = cmd_ready_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_ready_reg) begin
          if (cmd_fire) begin
            cmd_ready_next = 1'b0;
            write_next     = cmd_write;
            addr_next      = cmd_addr + BASE_ADDR;
            wdata_next     = cmd_wdata;
            wstrb_next     = cmd_wstrb;
          end
        end else if (write_reg) begin
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          arvalid_next = 1'b1;
        end
      end
      ST_WR: begin
        if (aw_fire) awvalid_next = 1'b0;
        if (w_fire) wvalid_next = 1'b0;
        aw_done_next = aw_done_now;
        w_done_next  = w_done_now;
        if (aw_done_now && w_done_now) bready_next = 1'b1;
      end
      ST_WR_RESP: begin
        if (b_fire) begin
          bready_next    = 1'b0;
          rsp_resp_next  = m_axi_bresp;
          rsp_rdata_next = '0;
          rsp_valid_next = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (ar_fire) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (r_fire) begin
          rready_next    = 1'b0;
          rsp_rdata_next = m_axi_rdata;
          rsp_resp_next  = m_axi_rresp;
          rsp_valid_next = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_valid_reg && rsp_ready) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
        end
      end
      default: begin
        cmd_ready_next = 1'b1;
      end
    endcase

    // A timed-out phase abandons the bus entirely; late responses then find no ready.
    if (timeout_hit) begin
      awvalid_next   = 1'b0;
      wvalid_next    = 1'b0;
      bready_next    = 1'b0;
      arvalid_next   = 1'b0;
      rready_next    = 1'b0;
      rsp_rdata_next = TIMEOUT_FILL;
      rsp_resp_next  = RESP_SLVERR;
      rsp_valid_next = 1'b1;
    end
  end

  assign cmd_ready     = cmd_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_axi_lite_master_cmd_if.sv
// Bench for axi_lite_master_cmd_if: a delay-programmable AXI4-Lite slave plus a
// command/response scoreboard. Build with AXI_LITE_MST_TIMEOUT_EN to add the watchdog case.
module tb_axi_lite_master_cmd_if;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction slave behaviour, set by the stimulus process.
  int          txn_id = 0;
  int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  // Slave-side observations.
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          aw_hs, w_hs, ar_hs;
  bit          aw_done, w_done, b_done, b_fire, ar_done, r_done, r_fire, w_first;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  axi_lite_master_cmd_if #(
    .BASE_ADDR      (BASE),
`ifdef AXI_LITE_MST_TIMEOUT_EN
    .TIMEOUT_CYCLES (16'd8)
`else
    .TIMEOUT_CYCLES (16'd1024)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awready (m_axi_awready),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bready  (m_axi_bready),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arready (m_axi_arready),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Slave model: decides readies/valids at the falling edge, so each handshake
  // it commits to completes on the following rising edge.
  initial begin
    int          last_id = -1;
    bit          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0;
    logic [3:0]  s_prev = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      if (txn_id != last_id) begin
        last_id = txn_id;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        aw_done = 0; w_done = 0; b_done = 0; b_fire = 0;
        ar_done = 0; r_done = 0; r_fire = 0; w_first = 0;
      end
      if (aw_wait) begin
        chk("awvalid_held", m_axi_awvalid, 1);
        chk("awaddr_stable", m_axi_awaddr, aw_prev);
      end
      if (w_wait) begin
        chk("wvalid_held", m_axi_wvalid, 1);
        chk("wdata_stable", m_axi_wdata, w_prev);
        chk("wstrb_stable", m_axi_wstrb, s_prev);
      end
      if (ar_wait) begin
        chk("arvalid_held", m_axi_arvalid, 1);
        chk("araddr_stable", m_axi_araddr, ar_prev);
      end
      if (m_axi_bready) chk("bready_after_aw_w", aw_done && w_done, 1);
      if (m_axi_awvalid && !m_axi_wvalid) w_first = 1;

      if (b_fire) begin
        m_axi_bvalid = 0; b_fire = 0; b_done = 1;
      end else if (m_axi_bvalid) begin
        if (m_axi_bready) b_fire = 1;
      end else if (aw_done && w_done && !b_done) begin
        if (b_cnt >= cfg_b_dly) begin
          m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
          if (m_axi_bready) b_fire = 1;
        end else b_cnt++;
      end

      if (r_fire) begin
        m_axi_rvalid = 0; r_fire = 0; r_done = 1;
      end else if (m_axi_rvalid) begin
        if (m_axi_rready) r_fire = 1;
      end else if (ar_done && !r_done) begin
        if (r_cnt >= cfg_r_dly) begin
          m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
          if (m_axi_rready) r_fire = 1;
        end else r_cnt++;
      end

      if (m_axi_awready) m_axi_awready = 0;
      else if (m_axi_awvalid && !aw_done) begin
        if (aw_cnt >= cfg_aw_dly) begin
          m_axi_awready = 1; aw_done = 1; cap_awaddr = m_axi_awaddr; aw_hs++;
        end else aw_cnt++;
      end
      if (m_axi_wready) m_axi_wready = 0;
      else if (m_axi_wvalid && !w_done) begin
        if (w_cnt >= cfg_w_dly) begin
          m_axi_wready = 1; w_done = 1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; w_hs++;
        end else w_cnt++;
      end
      if (m_axi_arready) m_axi_arready = 0;
      else if (m_axi_arvalid && !ar_done) begin
        if (ar_cnt >= cfg_ar_dly) begin
          m_axi_arready = 1; ar_done = 1; cap_araddr = m_axi_araddr; ar_hs++;
        end else ar_cnt++;
      end

      aw_wait = m_axi_awvalid && !m_axi_awready; aw_prev = m_axi_awaddr;
      w_wait  = m_axi_wvalid && !m_axi_wready;   w_prev = m_axi_wdata; s_prev = m_axi_wstrb;
      ar_wait = m_axi_arvalid && !m_axi_arready; ar_prev = m_axi_araddr;
    end
  end

  // One command end to end. Expected response: writes return zero data and the
  // slave's BRESP, reads return the slave's RDATA/RRESP, a watchdog expiry returns
  // SLVERR with the fill pattern. lat is the cycle (1 = cycle after accept) in
  // which rsp_valid is first seen.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int aw_d, input int w_d, input int b_d,
                        input int ar_d, input int r_d, input logic [1:0] resp,
                        input logic [31:0] rdata, input int hold, input bit poke,
                        input bit exp_tmo, output int lat);
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          w;
    @(negedge clk);
    cfg_aw_dly = aw_d; cfg_w_dly = w_d; cfg_b_dly = b_d; cfg_ar_dly = ar_d; cfg_r_dly = r_d;
    cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rdata;
    txn_id++;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("cmd_ready_drop", cmd_ready, 0);
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("rsp_valid_seen", rsp_valid, 1);

    if (exp_tmo) begin
      exp_rdata = 32'hDEAD_BEEF; exp_resp = 2'b10;
    end else begin
      exp_rdata = wr ? 32'h0 : rdata; exp_resp = resp;
    end
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_resp", rsp_resp, exp_resp);
    chk("bus_idle_in_rsp", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    if (wr) begin
      chk("awaddr", cap_awaddr, addr + BASE);
      chk("wdata", cap_wdata, data);
      chk("wstrb", cap_wstrb, strb);
      chk("aw_hs_count", aw_hs, 1);
      chk("w_hs_count", w_hs, 1);
    end else begin
      if (!exp_tmo) chk("araddr", cap_araddr, addr + BASE);
      chk("ar_hs_count", ar_hs, exp_tmo ? 0 : 1);
      chk("aw_hs_none", aw_hs, 0);
    end

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        cmd_valid = 1; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'hF;
      end
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
      chk("hold_rsp_resp", rsp_resp, exp_resp);
      chk("hold_cmd_ready", cmd_ready, 0);
      if (poke) chk("hold_no_new_axi", {m_axi_awvalid, m_axi_arvalid}, 0);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    rsp_ready = 0;
    $display("TXN %0d %s addr=0x%08h data=0x%08h rsp_rdata=0x%08h rsp_resp=%0d lat=%0d",
             txn_id, wr ? "WR" : "RD", addr, wr ? data : rdata, rsp_rdata, rsp_resp, lat);
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_wstrb", m_axi_wstrb, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Zero-wait write with base offset.
    do_txn(1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, lat);
    chk("wr_latency", lat, 4);
    // W handshakes three cycles before AW.
    do_txn(1, 32'h20, 32'h1357_9BDF, 4'h5, 3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, lat);
    chk("skew_w_first", w_first, 1);
    // Zero-wait read latency, then a read with slow rvalid.
    do_txn(0, 32'h24, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h7777_0001, 0, 0, 0, lat);
    chk("rd_latency", lat, 4);
    do_txn(0, 32'h30, 0, 0, 0, 0, 0, 2, 5, 2'b00, 32'h0BAD_CAFE, 0, 0, 0, lat);
    chk("rd_rvalid_wait", r_cnt, 5);
    // Response backpressure with a competing command.
    do_txn(1, 32'h40, 32'hCAFE_F00D, 4'h3, 1, 2, 1, 0, 0, 2'b00, 0, 10, 1, 0, lat);
    // DECERR passthrough, SLVERR read, address wrap.
    do_txn(1, 32'h44, 32'h0000_00FF, 4'h1, 0, 0, 2, 0, 0, 2'b11, 0, 0, 0, 0, lat);
    do_txn(0, 32'h48, 0, 0, 0, 0, 0, 1, 1, 2'b10, 32'h1122_3344, 0, 0, 0, lat);
    do_txn(1, 32'hC000_0004, 32'h0F0F_0F0F, 4'hA, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, lat);

`ifdef AXI_LITE_MST_TIMEOUT_EN
    do_txn(0, 32'h50, 0, 0, 0, 0, 0, 1000, 0, 2'b00, 32'h1234_5678, 0, 0, 1, lat);
    chk("tmo_arvalid_cycles", ar_cnt, 8);
`endif

    // Reset in the middle of a write.
    @(negedge clk);
    cfg_aw_dly = 3; cfg_w_dly = 3; cfg_b_dly = 0; txn_id++;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60; cmd_wdata = 32'h6060_6060; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("rstmid_awvalid_up", m_axi_awvalid, 1);
    #1 rst_n = 0;
    #1;
    chk("rstmid_valids_drop", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || m_axi_awvalid || m_axi_wvalid) seen = 1;
    end
    chk("rstmid_no_rsp", seen, 0);
    $display("TXN %0d WR addr=0x00000060 aborted by reset", txn_id);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      bit          wr;
      logic [31:0] a, d;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      do_txn(wr, a, d, 4'($urandom_range(0, 15)),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), $urandom_range(0, 4), 2'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_cmd_if.md
Name: axi_lite_master_cmd_if

Overview:
AXI4-Lite master that turns a simple single-outstanding command port (address, data, strobe, read/write) into AXI4-Lite transactions. It drives the AXI4-Lite slave peripherals in the design, such as the BRAM bridge, from local control logic such as sequencers or test engines. It returns one response (read data plus response code) per command. It is strictly one transaction at a time; there is no pipelining or ID reordering.

Parameters:
BASE_ADDR, 32'h0000_0000, added to cmd_addr to form AXI addresses (32-bit wrap, no overflow flag).
TIMEOUT_CYCLES, 16'd1024, watchdog limit per AXI phase; used only when the optional feature is compiled in.

Ports:
clk  in  1  single clock, all logic rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  byte offset
cmd_wdata  in  32  write data
cmd_wstrb  in  4  byte strobes (ignored for reads)
rsp_valid  out  1  response available, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
m_axi_awvalid/awaddr[31:0]/awready, m_axi_wvalid/wdata[31:0]/wstrb[3:0]/wready, m_axi_bvalid/bresp[1:0]/bready, m_axi_arvalid/araddr[31:0]/arready, m_axi_rvalid/rdata[31:0]/rresp[1:0]/rready: standard AXI4-Lite master-side directions.

Behaviour:
- Reset (async assert, sync deassert expected upstream): state = IDLE, cmd_ready = 1. All AXI valids and readies are 0, addr/data/strb are 0, rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0.
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready = 1. When a command is accepted, the block latches addr + BASE_ADDR, wdata and wstrb, and drops cmd_ready. On the next edge it goes to WR (awvalid = wvalid = 1) or RD_ADDR (arvalid = 1). The valids are asserted on the cycle after acceptance.
- WR: awvalid and wvalid are independent. Each drops on the edge where its own handshake completes. Two done-flags track completion, and AW and W may complete in the same cycle. When both are done, go to WR_RESP with bready = 1.
- WR_RESP: on bvalid & bready, capture bresp into rsp_resp, set rsp_rdata = 0, set bready = 0, go to RSP.
- RD_ADDR: on arvalid & arready, set arvalid = 0 and rready = 1, go to RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata and rresp, set rready = 0, go to RSP.
- RSP: rsp_valid = 1, with data and resp held stable. On rsp_valid & rsp_ready, set rsp_valid = 0 and cmd_ready = 1, return to IDLE. A new command can be accepted no earlier than the cycle after rsp_ready.
- Valid signals never deassert before their handshake completes, and address, data and strobe stay stable while valid is high, per AXI.
- The block never waits on a ready before asserting valid.
- Minimum write latency is 4 cycles and minimum read latency is 4 cycles, measured from cmd accept to rsp_valid, assuming a zero-wait slave.
- Slave responses SLVERR or DECERR are passed through unchanged. The block does not retry.
- Reset mid-transaction aborts immediately. All valids drop asynchronously, and no response is generated.

Optional Feature:
Macro AXI_LITE_MST_TIMEOUT_EN.
- Defined: a 16-bit counter restarts on every state entry and counts while in WR, WR_RESP, RD_ADDR or RD_DATA. When it reaches TIMEOUT_CYCLES, the block:
  - forces every AXI valid and ready to 0;
  - sets rsp_resp = 2'b10 (SLVERR) and rsp_rdata = 32'hDEAD_BEEF;
  - goes to RSP.
  Any later stray bvalid or rvalid is ignored in IDLE, because bready and rready are 0.
- Undefined: no counter exists, and the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds:
  - state encodings (4-bit localparams);
  - response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the timeout fill pattern 32'hDEAD_BEEF.
- No sub-module: the watchdog counter is inline. The state machine and the AXI channel registers live in a single module.

Test Plan:
- Write, zero-wait slave: cmd addr 0x10, data 0xA5A5_1234, strb 0xF, BASE_ADDR 0x4000_0000 -> awaddr 0x4000_0010, wdata 0xA5A5_1234, rsp_resp 0, rsp_valid 4 cycles after accept.
- AW/W skew: the slave asserts wready 3 cycles before awready -> wvalid drops first, and bready rises only after the AW handshake; a single response is returned.
- Read with rvalid delayed 5 cycles, rdata 0x0BAD_CAFE, rresp 2'b00 -> rsp_rdata 0x0BAD_CAFE, rsp_resp 0; arvalid held until arready.
- Backpressure: rsp_ready held low 10 cycles -> rsp_valid and data stable for all 10 cycles, cmd_ready stays 0, and a second cmd_valid is not accepted.
- Slave returns bresp 2'b11 -> rsp_resp 2'b11, no retry.
- With AXI_LITE_MST_TIMEOUT_EN and TIMEOUT_CYCLES = 8, arready stuck at 0 -> after 8 cycles arvalid = 0, rsp_resp 2'b10, rsp_rdata 0xDEAD_BEEF. Also: assert rst_n low mid-write -> all valids 0 immediately, no response.
